registers_bank_mp: RTL and testbench
====================================

REGISTERS_BANK_MP -- requirements
Module: registers_bank_mp

Interface
REQ-001 Parameter NB_DATA, default 32, register width in bits.
REQ-002 Parameter NB_ADDR, default 5, register address width.
REQ-003 Parameter BANK_DEPTH, default 32, number of registers; SHALL be ≤ 2**NB_ADDR and ≥ 2.
REQ-004 Parameter NUM_RD, default 2, number of read ports; SHALL be ≥ 1.
REQ-005 i_clock  input  1  clock; all state updates on rising edge.
REQ-006 i_reset  input  1  reset, synchronous, active-high.
REQ-007 i_enable  input  1  pipeline enable; read ports update only when high.
REQ-008 i_reg_write  input  1  write strobe, qualified by i_enable.
REQ-009 i_write_addr  input  NB_ADDR  write address.
REQ-010 i_write_data  input  NB_DATA  write data.
REQ-011 i_read_addr  input  NUM_RD*NB_ADDR  read addresses; port k occupies bits [k*NB_ADDR +: NB_ADDR].
REQ-012 o_read_data  output  NUM_RD*NB_DATA  registered read data; port k occupies bits [k*NB_DATA +: NB_DATA].
REQ-013 i_dump_start  input  1  debug request to stream the whole bank.
REQ-014 i_dump_ready  input  1  debug sink ready.
REQ-015 o_dump_valid  output  1  dump word valid.
REQ-016 o_dump_addr  output  NB_ADDR  address of the current dump word.
REQ-017 o_dump_data  output  NB_DATA  current dump word.
REQ-018 o_dump_busy  output  1  high while the FSM is not IDLE.
REQ-019 o_dump_done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-020 Write: when i_enable=1, i_reg_write=1 and i_write_addr < BANK_DEPTH, register[i_write_addr] SHALL take i_write_data at the clock edge; writes to addresses ≥ BANK_DEPTH SHALL be ignored.
REQ-021 Read, per port k, when i_enable=1: o_read_data[k] SHALL load register[addr_k] at the edge, giving 1-cycle latency.
REQ-022 Bypass: if a write is active in the same cycle and i_write_addr equals addr_k, port k SHALL load i_write_data; this applies independently to every port.
REQ-023 A read address ≥ BANK_DEPTH SHALL return 0.
REQ-024 When i_enable=0, all o_read_data SHALL hold their values and no write SHALL occur.
REQ-025 The dump FSM SHALL have states IDLE, DUMP and DONE.
REQ-026 IDLE→DUMP on i_dump_start=1: o_dump_addr←0, o_dump_data←register[0] (write-bypassed), o_dump_valid←1.
REQ-027 In DUMP, a transfer occurs when o_dump_valid & i_dump_ready; while valid is high and ready is low, o_dump_addr and o_dump_data SHALL hold stable.
REQ-028 On a transfer with o_dump_addr < BANK_DEPTH-1, the FSM SHALL increment o_dump_addr and load the next register (write-bypassed) in the same edge, so back-to-back transfers sustain one word per cycle.
REQ-029 On a transfer with o_dump_addr = BANK_DEPTH-1, the FSM SHALL move to DONE with o_dump_valid←0.
REQ-030 DONE SHALL assert o_dump_done for exactly one cycle and then return to IDLE.
REQ-031 i_dump_start SHALL be ignored outside IDLE.
REQ-032 o_dump_busy SHALL equal (state != IDLE).
REQ-033 The dump SHALL run concurrently with normal reads and writes; a write to an already-snapshotted o_dump_data word SHALL NOT alter it.

Reset
REQ-034 When i_reset=1 at an edge, all registers, all o_read_data, o_dump_data and o_dump_addr SHALL be 0, o_dump_valid, o_dump_busy and o_dump_done SHALL be 0, and the FSM SHALL be IDLE.
REQ-035 Reset SHALL take priority over every write, read or dump in progress; an aborted dump SHALL not pulse o_dump_done.

Configuration
REQ-036 Macro REGFILE_ZERO_REG_EN defined: register 0 SHALL be hardwired to 0, writes to address 0 SHALL be ignored, and reads, bypass and dump of address 0 SHALL return 0.
REQ-037 Macro REGFILE_ZERO_REG_EN undefined: register 0 SHALL behave as an ordinary register.

Verification
REQ-038 Reset, then write 0xDEADBEEF to address 5 with i_enable=1; next cycle read port 0 at address 5 -> o_read_data[0]=0xDEADBEEF one cycle later.
REQ-039 Same-cycle write of 0x12345678 to address 7 with port 0 and port 1 both reading address 7 -> both ports show 0x12345678 after one edge.
REQ-040 i_enable=0 with write strobe to address 3 and a changed read address -> outputs hold, and register 3 remains unchanged on a later read.
REQ-041 Load register[i]=i+0x100, pulse i_dump_start, hold i_dump_ready=1 -> 32 consecutive words addr 0..31 with data 0x100..0x11F, then o_dump_done pulses once and o_dump_busy falls.
REQ-042 Dump with i_dump_ready low for 3 cycles at addr 4 -> addr and data stay stable at 4/0x104; assert reset mid-dump -> valid and busy drop to 0 and no done pulse occurs.
REQ-043 With REGFILE_ZERO_REG_EN defined, write 0xFFFFFFFF to address 0 -> reads and dump of address 0 return 0; with the macro undefined, reads return 0xFFFFFFFF.

Source files
------------

// File: rtl/registers_bank_mp.sv
// Multi-read-port register bank with write bypass and a debug dump streamer.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module registers_bank_mp #(
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned NB_ADDR    = 5,
  parameter int unsigned BANK_DEPTH = 32,
  parameter int unsigned NUM_RD     = 2
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_reg_write,
  input  logic [NB_ADDR-1:0]         i_write_addr,
  input  logic [NB_DATA-1:0]         i_write_data,
  input  logic [NUM_RD*NB_ADDR-1:0]  i_read_addr,
  output logic [NUM_RD*NB_DATA-1:0]  o_read_data,
  input  logic                       i_dump_start,
  input  logic                       i_dump_ready,
  output logic                       o_dump_valid,
  output logic [NB_ADDR-1:0]         o_dump_addr,
  output logic [NB_DATA-1:0]         o_dump_data,
  output logic                       o_dump_busy,
  output logic                       o_dump_done
);

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(BANK_DEPTH - 1);

  state_t             state;
  logic [NB_DATA-1:0] bank [BANK_DEPTH];
  logic               wr_en_c;

  function automatic logic in_range(input logic [NB_ADDR-1:0] a);
    return 32'(a) < BANK_DEPTH;
  endfunction

  // Current-cycle view of a register, including a same-edge write
  function automatic logic [NB_DATA-1:0] read_word(input logic [NB_ADDR-1:0] a);
    logic [NB_DATA-1:0] w;
    if (!in_range(a))
      w = '0;
    else if (wr_en_c && (i_write_addr == a))
      w = i_write_data;
    else
      w = bank[a];
`ifdef REGFILE_ZERO_REG_EN
    if (a == '0)
      w = '0;
`endif
    return w;
  endfunction

  always_comb begin
    wr_en_c = i_enable & i_reg_write & in_range(i_write_addr);
`ifdef REGFILE_ZERO_REG_EN
    wr_en_c = wr_en_c & (i_write_addr != '0);
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < BANK_DEPTH; i++)
        bank[i] <= '0;
    end else if (wr_en_c) begin
      bank[i_write_addr] <= i_write_data;
    end
  end

  // Read ports update only while the pipeline is enabled
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_read_data <= '0;
    end else if (i_enable) begin
      for (int unsigned k = 0; k < NUM_RD; k++)
        o_read_data[k*NB_DATA +: NB_DATA] <= read_word(i_read_addr[k*NB_ADDR +: NB_ADDR]);
    end
  end

  // Dump streamer; the next word is fetched on the same edge as a transfer
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      o_dump_valid <= 1'b0;
      o_dump_addr  <= '0;
      o_dump_data  <= '0;
      o_dump_busy  <= 1'b0;
      o_dump_done  <= 1'b0;
    end else begin
      o_dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_dump_start) begin
            state        <= DUMP;
            o_dump_busy  <= 1'b1;
            o_dump_valid <= 1'b1;
            o_dump_addr  <= '0;
            o_dump_data  <= read_word('0);
          end
        end
        DUMP: begin
          if (o_dump_valid && i_dump_ready) begin
            if (o_dump_addr != LAST_ADDR) begin
              o_dump_addr <= o_dump_addr + NB_ADDR'(1);
              o_dump_data <= read_word(o_dump_addr + NB_ADDR'(1));
            end else begin
              state        <= DONE;
              o_dump_valid <= 1'b0;
              o_dump_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          o_dump_busy <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          o_dump_valid <= 1'b0;
          o_dump_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_registers_bank_mp.sv
// Self-checking bench for registers_bank_mp: directed scenarios plus random traffic
// compared every cycle against an array-based reference model.
module tb_registers_bank_mp;

  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int DEPTH   = 32;
  localparam int NUM_RD  = 2;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      enable;
  logic                      reg_write;
  logic [NB_ADDR-1:0]        write_addr;
  logic [NB_DATA-1:0]        write_data;
  logic [NUM_RD*NB_ADDR-1:0] read_addr;
  logic [NUM_RD*NB_DATA-1:0] read_data;
  logic                      dump_start;
  logic                      dump_ready;
  logic                      dump_valid;
  logic [NB_ADDR-1:0]        dump_addr;
  logic [NB_DATA-1:0]        dump_data;
  logic                      dump_busy;
  logic                      dump_done;

  always #5 clock = ~clock;

  registers_bank_mp #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .BANK_DEPTH(DEPTH), .NUM_RD(NUM_RD)
  ) dut (
    .i_clock(clock), .i_reset(reset), .i_enable(enable), .i_reg_write(reg_write),
    .i_write_addr(write_addr), .i_write_data(write_data), .i_read_addr(read_addr),
    .o_read_data(read_data), .i_dump_start(dump_start), .i_dump_ready(dump_ready),
    .o_dump_valid(dump_valid), .o_dump_addr(dump_addr), .o_dump_data(dump_data),
    .o_dump_busy(dump_busy), .o_dump_done(dump_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, expected port values, dump progress
  logic [NB_DATA-1:0] mem [DEPTH];
  logic [NB_DATA-1:0] exp_rd [NUM_RD];
  int                 dphase;   // 0 idle, 1 streaming, 2 finishing
  int                 dpos;
  logic               exp_valid, exp_busy, exp_done;
  logic [NB_ADDR-1:0] exp_daddr;
  logic [NB_DATA-1:0] exp_ddata;
  bit                 model_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int a;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      for (int k = 0; k < NUM_RD; k++) exp_rd[k] = '0;
      dphase = 0; dpos = 0;
      exp_valid = 0; exp_busy = 0; exp_done = 0;
      exp_daddr = '0; exp_ddata = '0;
      model_ok = 1'b1;
    end else begin
      // Writes land first so reads and dump fetches see the bypassed value
      if (enable && reg_write && int'(write_addr) < DEPTH && !(ZERO && write_addr == '0))
        mem[write_addr] = write_data;
      if (enable)
        for (int k = 0; k < NUM_RD; k++) begin
          a = int'(read_addr[k*NB_ADDR +: NB_ADDR]);
          exp_rd[k] = (a < DEPTH) ? mem[a] : '0;
        end
      exp_done = 0;
      case (dphase)
        0: if (dump_start) begin
          dphase = 1; dpos = 0;
          exp_valid = 1; exp_busy = 1;
          exp_daddr = '0; exp_ddata = mem[0];
        end
        1: if (dump_ready) begin
          if (dpos < DEPTH - 1) begin
            dpos++;
            exp_daddr = NB_ADDR'(dpos);
            exp_ddata = mem[dpos];
          end else begin
            dphase = 2; exp_valid = 0; exp_done = 1;
          end
        end
        default: begin
          dphase = 0; exp_busy = 0;
        end
      endcase
    end
  endtask

  task automatic compare_all();
    if (!model_ok) return;
    for (int k = 0; k < NUM_RD; k++)
      chk($sformatf("rd%0d", k), read_data[k*NB_DATA +: NB_DATA], exp_rd[k]);
    chk("dump_valid", 32'(dump_valid), 32'(exp_valid));
    chk("dump_busy", 32'(dump_busy), 32'(exp_busy));
    chk("dump_done", 32'(dump_done), 32'(exp_done));
    if (exp_valid) begin
      chk("dump_addr", 32'(dump_addr), 32'(exp_daddr));
      chk("dump_data", dump_data, exp_ddata);
    end
  endtask

  // Inputs change after the falling edge; the model steps on the rising edge
  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  initial begin
    logic [NB_ADDR-1:0] ra;
    int                 guard;
    reset = 1; enable = 0; reg_write = 0; write_addr = '0; write_data = '0;
    read_addr = '0; dump_start = 0; dump_ready = 0;
    cycle(); cycle();
    reset = 0;
    chk("rst_rd0", read_data[31:0], 32'h0);
    chk("rst_busy", 32'(dump_busy), 32'h0);

    // Write then read back
    enable = 1; reg_write = 1; write_addr = 5'd5; write_data = 32'hDEADBEEF;
    cycle();
    reg_write = 0; read_addr = 10'd5;
    cycle();
    chk("wr_rd5", read_data[31:0], 32'hDEADBEEF);
    chk("model_pin_rd5", exp_rd[0], 32'hDEADBEEF);

    // Same-cycle bypass on both ports
    reg_write = 1; write_addr = 5'd7; write_data = 32'h12345678; read_addr = {5'd7, 5'd7};
    cycle();
    chk("byp_p0", read_data[31:0], 32'h12345678);
    chk("byp_p1", read_data[63:32], 32'h12345678);

    // Disabled: no write, outputs hold
    enable = 0; reg_write = 1; write_addr = 5'd3; write_data = 32'hAAAA5555;
    read_addr = {5'd3, 5'd3};
    cycle();
    chk("hold_p0", read_data[31:0], 32'h12345678);
    chk("hold_p1", read_data[63:32], 32'h12345678);
    enable = 1; reg_write = 0;
    cycle();
    chk("nowr_r3", read_data[31:0], 32'h0);

    // Register 0 behaviour
    reg_write = 1; write_addr = 5'd0; write_data = 32'hFFFFFFFF; read_addr = '0;
    cycle();
    chk("r0_bypass", read_data[31:0], ZERO ? 32'h0 : 32'hFFFFFFFF);
    reg_write = 0;
    cycle();
    chk("r0_read", read_data[31:0], ZERO ? 32'h0 : 32'hFFFFFFFF);

    // Full dump with ready held high
    reg_write = 1;
    for (int i = 0; i < DEPTH; i++) begin
      write_addr = NB_ADDR'(i); write_data = 32'h100 + 32'(i);
      cycle();
    end
    reg_write = 0; dump_start = 1; dump_ready = 1;
    cycle();
    dump_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      chk("seq_valid", 32'(dump_valid), 32'h1);
      chk("seq_addr", 32'(dump_addr), 32'(i));
      chk("seq_data", dump_data, (ZERO && i == 0) ? 32'h0 : 32'h100 + 32'(i));
      cycle();
    end
    chk("seq_done", 32'(dump_done), 32'h1);
    chk("seq_valid_end", 32'(dump_valid), 32'h0);
    cycle();
    chk("seq_done_once", 32'(dump_done), 32'h0);
    chk("seq_busy_end", 32'(dump_busy), 32'h0);

    // Stall at address 4, then abort with reset
    dump_start = 1;
    cycle();
    dump_start = 0;
    repeat (4) cycle();
    chk("stall_addr0", 32'(dump_addr), 32'h4);
    dump_ready = 0;
    repeat (3) begin
      cycle();
      chk("stall_addr", 32'(dump_addr), 32'h4);
      chk("stall_data", dump_data, 32'h104);
    end
    reset = 1;
    cycle();
    chk("abort_valid", 32'(dump_valid), 32'h0);
    chk("abort_busy", 32'(dump_busy), 32'h0);
    reset = 0;
    repeat (4) begin
      cycle();
      chk("abort_no_done", 32'(dump_done), 32'h0);
    end

    // Random traffic
    repeat (3000) begin
      reset      = ($urandom % 600) == 0;
      enable     = ($urandom % 8) != 0;
      reg_write  = 1'($urandom);
      write_addr = NB_ADDR'($urandom);
      write_data = $urandom;
      for (int k = 0; k < NUM_RD; k++) begin
        ra = (($urandom % 3) == 0) ? write_addr : NB_ADDR'($urandom);
        read_addr[k*NB_ADDR +: NB_ADDR] = ra;
      end
      dump_start = ($urandom % 40) == 0;
      dump_ready = ($urandom % 4) != 0;
      cycle();
    end

    // Drain any dump in flight
    reset = 0; dump_start = 0; dump_ready = 1; reg_write = 0;
    guard = 0;
    while (dump_busy && guard < 40) begin
      cycle();
      guard++;
    end
    chk("drain_busy", 32'(dump_busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
